// File: rtl/filter_input_buffer.sv
// Circular sample history feeding the MAC one tap per cycle, newest sample first.
// Optional sticky drop flag is built only when FILTER_INPUT_OVF_FLAG_EN is defined.
module filter_input_buffer #(
  parameter int NUM_TAPS = 16,
  parameter int ADDR_W   = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic                       trig_input_ovf_flag_clear,
  output logic signed [SAMPLE_W-1:0] mac_sample,
  output logic        [ADDR_W-1:0]   mac_tap,
  output logic                       mac_valid,
  output logic                       mac_first,
  output logic                       mac_last,
  output logic                       ro_input_ovf_flag
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic signed [SAMPLE_W-1:0] r_mem [NUM_TAPS];
  logic        [ADDR_W-1:0]   r_wp;
  logic        [ADDR_W-1:0]   r_nw;
  logic        [ADDR_W-1:0]   r_k;

  logic signed [SAMPLE_W-1:0] r_macSample;
  logic        [ADDR_W-1:0]   r_macTap;
  logic                       r_macValid;
  logic                       r_macFirst;
  logic                       r_macLast;

  logic signed [SAMPLE_W-1:0] w_macSampleNext;
  logic        [ADDR_W-1:0]   w_macTapNext;
  logic                       w_macValidNext;
  logic                       w_macFirstNext;
  logic                       w_macLastNext;
  logic        [ADDR_W-1:0]   w_kNext;
  logic        [ADDR_W-1:0]   w_rdAddr;
  logic                       w_accept;
  logic                       w_drop;

  assign w_rdAddr = r_nw - r_k;

  // Tap 0 is taken straight from sample_in on the accept edge, so r_k already
  // points at tap 1 when RUN starts; RUN ends on the edge after mac_last.
  always_comb begin
    w_stateNext     = r_state;
    w_accept        = 1'b0;
    w_drop          = 1'b0;
    w_macValidNext  = 1'b0;
    w_macFirstNext  = 1'b0;
    w_macLastNext   = 1'b0;
    w_macSampleNext = r_macSample;
    w_macTapNext    = r_macTap;
    w_kNext         = r_k;
    case (r_state)
      ST_IDLE: begin
        if (sample_valid) begin
          w_accept        = 1'b1;
          w_stateNext     = ST_RUN;
          w_macValidNext  = 1'b1;
          w_macFirstNext  = 1'b1;
          w_macSampleNext = sample_in;
          w_macTapNext    = '0;
          w_kNext         = ADDR_W'(1);
        end
      end
      ST_RUN: begin
        w_drop = sample_valid;
        if (r_macLast) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_macValidNext  = 1'b1;
          w_macSampleNext = r_mem[w_rdAddr];
          w_macTapNext    = r_k;
          w_macLastNext   = (r_k == LAST_TAP);
          w_kNext         = r_k + ADDR_W'(1);
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wp        <= '0;
      r_nw        <= '0;
      r_k         <= '0;
      r_macSample <= '0;
      r_macTap    <= '0;
      r_macValid  <= 1'b0;
      r_macFirst  <= 1'b0;
      r_macLast   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state     <= w_stateNext;
      r_k         <= w_kNext;
      r_macSample <= w_macSampleNext;
      r_macTap    <= w_macTapNext;
      r_macValid  <= w_macValidNext;
      r_macFirst  <= w_macFirstNext;
      r_macLast   <= w_macLastNext;
      if (w_accept) begin
        r_mem[r_wp] <= sample_in;
        r_nw        <= r_wp;
        r_wp        <= r_wp + 1'b1;
      end
    end
  end

  assign sample_ready = (r_state == ST_IDLE);
  assign mac_sample   = r_macSample;
  assign mac_tap      = r_macTap;
  assign mac_valid    = r_macValid;
  assign mac_first    = r_macFirst;
  assign mac_last     = r_macLast;

`ifdef FILTER_INPUT_OVF_FLAG_EN
  logic r_ovfFlag;

  // Clear takes priority over a simultaneous drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovfFlag <= 1'b0;
    end else if (trig_input_ovf_flag_clear) begin
      r_ovfFlag <= 1'b0;
    end else if (w_drop) begin
      r_ovfFlag <= 1'b1;
    end
  end

  assign ro_input_ovf_flag = r_ovfFlag;
`else
  logic [1:0] w_unusedFlagInputs;

  assign w_unusedFlagInputs = {trig_input_ovf_flag_clear, w_drop};
  assign ro_input_ovf_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_filter_input_buffer.sv
// Bench for filter_input_buffer: directed scenarios plus random traffic checked
// every cycle against a history-queue model of the tap stream.
module tb_filter_input_buffer;

  localparam int NUM_TAPS = 16;
  localparam int ADDR_W   = 4;
  localparam int SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                trig_input_ovf_flag_clear;
  logic [SAMPLE_W-1:0] mac_sample;
  logic [ADDR_W-1:0]   mac_tap;
  logic                mac_valid;
  logic                mac_first;
  logic                mac_last;
  logic                ro_input_ovf_flag;

  always #5 clk = ~clk;

  filter_input_buffer #(
    .NUM_TAPS(NUM_TAPS),
    .ADDR_W  (ADDR_W),
    .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .sample_in                (sample_in),
    .sample_valid             (sample_valid),
    .sample_ready             (sample_ready),
    .trig_input_ovf_flag_clear(trig_input_ovf_flag_clear),
    .mac_sample               (mac_sample),
    .mac_tap                  (mac_tap),
    .mac_valid                (mac_valid),
    .mac_first                (mac_first),
    .mac_last                 (mac_last),
    .ro_input_ovf_flag        (ro_input_ovf_flag)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: every accepted sample in arrival order, plus the number
  // of tap cycles still to be emitted for the current sequence.
  logic [SAMPLE_W-1:0] hist [$];
  int                  busyLeft;
  logic                flagExp;
  logic [SAMPLE_W-1:0] lastSample;
  logic [ADDR_W-1:0]   lastTap;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [SAMPLE_W-1:0] tapValue(input int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return '0;
  endfunction

  task automatic checkAll();
    checkOutput("sample_ready", 32'(sample_ready), 32'(busyLeft == 0));
    checkOutput("mac_valid", 32'(mac_valid), 32'(busyLeft > 0));
    checkOutput("mac_first", 32'(mac_first), 32'(busyLeft == NUM_TAPS));
    checkOutput("mac_last", 32'(mac_last), 32'(busyLeft == 1));
    checkOutput("mac_sample", 32'(mac_sample), 32'(lastSample));
    checkOutput("mac_tap", 32'(mac_tap), 32'(lastTap));
    checkOutput("ovf_flag", 32'(ro_input_ovf_flag), 32'(flagExp));
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [SAMPLE_W-1:0] d, input logic clr);
    rst_n                     = rst;
    sample_valid              = v;
    sample_in                 = d;
    trig_input_ovf_flag_clear = clr;
    @(posedge clk);
    if (!rst) begin
      hist.delete();
      busyLeft   = 0;
      flagExp    = 1'b0;
      lastSample = '0;
      lastTap    = '0;
    end else begin
`ifdef FILTER_INPUT_OVF_FLAG_EN
      if (clr) flagExp = 1'b0;
      else if (v && busyLeft != 0) flagExp = 1'b1;
`endif
      if (busyLeft == 0) begin
        if (v) begin
          hist.push_back(d);
          busyLeft = NUM_TAPS;
        end
      end else begin
        busyLeft--;
      end
      if (busyLeft > 0) begin
        lastTap    = ADDR_W'(NUM_TAPS - busyLeft);
        lastSample = tapValue(NUM_TAPS - busyLeft);
      end
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic sendSample(input logic [SAMPLE_W-1:0] d);
    applyStimulus(1'b1, 1'b1, d, 1'b0);
    idle(NUM_TAPS);
  endtask

  initial begin
    rst_n                     = 1'b0;
    sample_valid              = 1'b0;
    sample_in                 = '0;
    trig_input_ovf_flag_clear = 1'b0;
    busyLeft                  = 0;
    flagExp                   = 1'b0;
    lastSample                = '0;
    lastTap                   = '0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    idle(2);

    sendSample(16'h1234);
    idle(1);

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 20; i++) sendSample(16'(i));
    idle(1);

    // Drop during RUN at the third cycle after accept
    applyStimulus(1'b1, 1'b1, 16'h0AAA, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0);
    idle(13);
    idle(3);

    // Clear coinciding with a drop, then a lone drop and a lone clear
    applyStimulus(1'b1, 1'b1, 16'h0BBB, 1'b0);
    idle(4);
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b1);
    idle(11);
    idle(1);
    applyStimulus(1'b1, 1'b1, 16'h0CCC, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h6666, 1'b0);
    idle(14);
    idle(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    idle(2);

    // Reset while tap 7 is on the outputs
    applyStimulus(1'b1, 1'b1, 16'h0DDD, 1'b0);
    idle(7);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    idle(2);
    sendSample(16'h0EEE);
    idle(1);

    sendSample(16'h8000);
    sendSample(16'hFFFF);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 3) == 0),
                    16'($urandom),
                    ($urandom_range(0, 9) == 0));
    end
    idle(NUM_TAPS + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_input_buffer.md
# filter_input_buffer

Input-side companion to the filter output stage. It accepts 16-bit signed samples through a valid/ready handshake and stores them in a circular history buffer of NUM_TAPS entries. For each accepted sample it streams the full history, x[n], x[n-1], … x[n-NUM_TAPS+1], to the MAC with tap indices and first/last markers. The MAC's accumulated result then goes to the round/truncate stage.

## Interface
- NUM_TAPS, 16, history depth and taps per output; must equal 2**ADDR_W.
- ADDR_W, 4, buffer/tap index width.
- SAMPLE_W, 16, sample width (signed).

- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- sample_in  in  SAMPLE_W  new input sample x[n], signed.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block can accept a sample this cycle.
- trig_input_ovf_flag_clear  in  1  single-cycle clear of ro_input_ovf_flag.
- mac_sample  out  SAMPLE_W  history sample x[n-k].
- mac_tap  out  ADDR_W  coefficient index k.
- mac_valid  out  1  mac_sample/mac_tap are valid.
- mac_first  out  1  k==0; MAC clears its accumulator.
- mac_last  out  1  k==NUM_TAPS-1; MAC result is complete.
- ro_input_ovf_flag  out  1  sticky flag: a sample was dropped.

## Operation
- Storage: NUM_TAPS x SAMPLE_W flop array mem, write pointer wp[ADDR_W-1:0], newest-index register nw, tap counter k.
- FSM has two states.
  - IDLE: sample_ready=1, mac_valid=0. If sample_valid: mem[wp]<=sample_in, nw<=wp, wp<=wp+1 (natural wrap, 15 -> 0), k<=0, go RUN.
  - RUN: sample_ready=0. Each cycle: mac_valid=1, mac_tap=k, mac_sample=mem[(nw-k) mod NUM_TAPS], mac_first=(k==0), mac_last=(k==NUM_TAPS-1), k<=k+1. On k==NUM_TAPS-1 go IDLE.
- Address arithmetic is ADDR_W-bit unsigned subtraction; wrap is implicit.
- Outputs are registered. mac_sample/mac_tap hold their last value when mac_valid=0; consumers must qualify with mac_valid.
- Drop rule: sample_valid=1 while sample_ready=0 is ignored. Memory, wp and the sequence are unaffected, and ro_input_ovf_flag<=1.
- Flag: trig_input_ovf_flag_clear clears it. A clear and a set in the same cycle resolve to clear.
- No backpressure from the MAC. It must accept one tap per cycle.

## Timing
- Reset (rst_n=0 at posedge), all synchronous:
  - mem all 0, wp=0, nw=0, k=0, state IDLE.
  - sample_ready=1, mac_valid=0, mac_first=0, mac_last=0, mac_sample=0, mac_tap=0, ro_input_ovf_flag=0.
- Reset mid-RUN aborts the sequence. mac_valid=0 from the cycle after reset is sampled, and no mac_last is issued.
- Sample accepted at edge T:
  - sample_ready=0 from T+1.
  - mac_valid=1 on cycles T+1 … T+NUM_TAPS.
  - mac_first at T+1, mac_last at T+NUM_TAPS.
  - sample_ready=1 again at T+NUM_TAPS+1.
- Minimum sample spacing is NUM_TAPS+1 cycles (17 at default). Latency from accept to first tap is 1 cycle.
- Before NUM_TAPS samples have arrived, older taps read 0 (reset history).

## Configuration
- FILTER_INPUT_OVF_FLAG_EN defined: drop detection and ro_input_ovf_flag behave as above.
- Not defined:
  - ro_input_ovf_flag is tied to 0 and trig_input_ovf_flag_clear is ignored.
  - Dropped samples are still discarded silently with no other behaviour change.
  - No flag logic is synthesized.

## Test plan
- After reset, check outputs. Then drive sample_in=0x1234 with sample_valid for one cycle -> 16 cycles of mac_valid; tap 0 = 0x1234 with mac_first; taps 1..15 = 0x0000; mac_last on tap 15; sample_ready=1 on the 17th cycle after accept.
- Feed 20 samples 1..20 at 17-cycle spacing; after the last -> taps 0..15 = 20,19,…,5, confirming the wp wrap 15->0.
- Drive sample_valid at T+3 during RUN with value 0x7FFF -> sample dropped, later sequence excludes 0x7FFF, ro_input_ovf_flag=1 from T+4 and held.
- Pulse trig_input_ovf_flag_clear in the same cycle as a new drop -> flag=0. Pulse the clear alone -> flag=0. Repeat without FILTER_INPUT_OVF_FLAG_EN -> flag always 0.
- Assert rst_n=0 at tap 7 of a sequence -> mac_valid=0 next cycle, no mac_last; the next sample yields tap 0 = new sample and taps 1..15 = 0.
- Negative values 0x8000 and 0xFFFF pass through unchanged as taps 1 and 0 respectively.
